sja1000_frame_loader: RTL

- Upstream sequencer for the SJA1000-compatible controller (can_top_raw) in PeliCAN/extended mode.
- Accepts one CAN frame descriptor over a valid/ready handshake and writes frame info, ID and data bytes into the controller TX buffer port (tx_we/tx_addr/tx_data).
- Issues the transmit-request command, waits for the active-low interrupt, reads the Interrupt Register and reports completion status.
- Replaces bench-side task sequencing so directed and looped frame traffic can be generated in RTL.

---
 rtl/sja1000_frame_loader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sja1000_frame_loader.sv
// -----------------------------------------------------------------------------
// sja1000_frame_loader
//
// Sequencer in front of an SJA1000-compatible CAN controller running in
// PeliCAN (extended) mode. It accepts one frame descriptor, writes the frame
// into the controller TX buffer, requests transmission, then waits for the
// interrupt, reads the Interrupt Register and reports how the frame ended.
//
// Ports
//   clk_i, res_n            clock, asynchronous active-low reset
//   frm_valid_i/frm_ready_o descriptor handshake (accepted on valid & ready)
//   frm_ext_i, frm_rtr_i,
//   frm_id_i, frm_dlc_i,
//   frm_data_i              descriptor fields; frm_data_i[63:56] is data byte 0
//   tx_we_o/addr_o/data_o   TX buffer byte write port (offsets 0..12)
//   reg_we_o/addr_write_o/
//   reg_data_o              register write port (command register writes)
//   reg_re_o/addr_read_o    register read strobe; reg_data_i valid next cycle
//   irq_ni, bus_off_i       controller interrupt (active low), bus-off flag
//   done_o                  one-cycle completion pulse
//   status_o                {timeout, error, ok}, held until the next accept
// -----------------------------------------------------------------------------
module sja1000_frame_loader #(
   parameter int TIMEOUT_CYC = 2000000,
   parameter int TO_W        = 21
) (
   input  logic        clk_i,
   input  logic        res_n,
   input  logic        frm_valid_i,
   output logic        frm_ready_o,
   input  logic        frm_ext_i,
   input  logic        frm_rtr_i,
   input  logic [28:0] frm_id_i,
   input  logic [3:0]  frm_dlc_i,
   input  logic [63:0] frm_data_i,
   output logic        tx_we_o,
   output logic [3:0]  tx_addr_o,
   output logic [7:0]  tx_data_o,
   output logic        reg_we_o,
   output logic [7:0]  reg_addr_write_o,
   output logic [7:0]  reg_data_o,
   output logic        reg_re_o,
   output logic [7:0]  reg_addr_read_o,
   input  logic [7:0]  reg_data_i,
   input  logic        irq_ni,
   input  logic        bus_off_i,
   output logic        done_o,
   output logic [2:0]  status_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CMD, S_WAIT, S_RD, S_EVAL, S_ABORT, S_DONE
   } state_t;

   localparam logic [7:0] ADDR_CMD = 8'd1;
   localparam logic [7:0] ADDR_IR  = 8'd3;
   localparam logic [7:0] CMD_TR   = 8'h01;
   localparam logic [7:0] CMD_AT   = 8'h02;

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              ext_q, ext_d;
   logic              rtr_q, rtr_d;
   logic [28:0]       id_q, id_d;
   logic [3:0]        dlc_q, dlc_d;
   logic [63:0]       data_q, data_d;
   logic [2:0]        status_q, status_d;

   // Derived from the latched descriptor, not the live inputs.
   logic [3:0]  id_len;
   logic [3:0]  n_data;
   logic [3:0]  last_idx;
   logic [31:0] id_word;
   logic [31:0] id_shift;
   logic [1:0]  id_sel;
   logic [3:0]  data_idx;
   logic [63:0] data_shift;
   logic [7:0]  load_byte;

   // NOTE: every signal written below gets its default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      to_cnt_d = to_cnt_q;
      ext_d    = ext_q;
      rtr_d    = rtr_q;
      id_d     = id_q;
      dlc_d    = dlc_q;
      data_d   = data_q;
      status_d = status_q;

      frm_ready_o      = 1'b0;
      tx_we_o          = 1'b0;
      tx_addr_o        = 4'd0;
      tx_data_o        = 8'd0;
      reg_we_o         = 1'b0;
      reg_addr_write_o = 8'd0;
      reg_data_o       = 8'd0;
      reg_re_o         = 1'b0;
      reg_addr_read_o  = 8'd0;
      done_o           = 1'b0;

      // DLC 9..15 still carries only 8 data bytes; remote frames carry none.
      id_len   = ext_q ? 4'd4 : 4'd2;
      n_data   = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
      last_idx = id_len + n_data;

      // ID left-aligned in a 32-bit word; byte k of the ID field is then
      // simply the top byte after shifting left by k bytes. Offset 4 wraps
      // the 2-bit selector to 3, which is the last extended ID byte.
      id_word    = ext_q ? {id_q, 3'b000} : {id_q[10:0], 5'b00000, 16'h0000};
      id_sel     = idx_q[1:0] - 2'd1;
      id_shift   = id_word << {id_sel, 3'b000};
      data_idx   = idx_q - id_len - 4'd1;
      data_shift = data_q << {data_idx[2:0], 3'b000};

      if (idx_q == 4'd0)
         load_byte = {ext_q, rtr_q, 2'b00, dlc_q};
      else if (idx_q <= id_len)
         load_byte = id_shift[31:24];
      else
         load_byte = data_shift[63:56];

      case (state_q)
         S_IDLE: begin
            frm_ready_o = 1'b1;
            if (frm_valid_i) begin
               ext_d    = frm_ext_i;
               rtr_d    = frm_rtr_i;
               id_d     = frm_id_i;
               dlc_d    = frm_dlc_i;
               data_d   = frm_data_i;
               status_d = 3'b000;
               idx_d    = 4'd0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            tx_we_o   = 1'b1;
            tx_addr_o = idx_q;
            tx_data_o = load_byte;
            if (idx_q == last_idx)
               state_d = S_CMD;
            else
               idx_d = idx_q + 4'd1;
         end
         S_CMD: begin
            reg_we_o         = 1'b1;
            reg_addr_write_o = ADDR_CMD;
            reg_data_o       = CMD_TR;
            to_cnt_d         = '0;
            state_d          = S_WAIT;
         end
         S_WAIT: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (bus_off_i) begin
               status_d = 3'b010;
               state_d  = S_DONE;
            // >= rather than == so a limit crossed during RD/EVAL still aborts.
            end else if (to_cnt_q >= TO_W'(TIMEOUT_CYC - 1)) begin
               state_d = S_ABORT;
            end else if (!irq_ni) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            to_cnt_d        = to_cnt_q + 1'b1;
            reg_re_o        = 1'b1;
            reg_addr_read_o = ADDR_IR;
            state_d         = S_EVAL;
         end
         S_EVAL: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (reg_data_i[1]) begin
               status_d = 3'b001;
               state_d  = S_DONE;
            end else if (reg_data_i[7] && bus_off_i) begin
               status_d = 3'b010;
               state_d  = S_DONE;
            end else begin
               // RI/ALI/EPI only: the controller retries on its own.
               state_d = S_WAIT;
            end
         end
         S_ABORT: begin
            reg_we_o         = 1'b1;
            reg_addr_write_o = ADDR_CMD;
            reg_data_o       = CMD_AT;
            status_d         = 3'b100;
            state_d          = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign status_o = status_q;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before this edge, independent of block order.
   always_ff @(posedge clk_i or negedge res_n) begin
      if (!res_n) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         to_cnt_q <= '0;
         ext_q    <= 1'b0;
         rtr_q    <= 1'b0;
         id_q     <= 29'd0;
         dlc_q    <= 4'd0;
         data_q   <= 64'd0;
         status_q <= 3'b000;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         to_cnt_q <= to_cnt_d;
         ext_q    <= ext_d;
         rtr_q    <= rtr_d;
         id_q     <= id_d;
         dlc_q    <= dlc_d;
         data_q   <= data_d;
         status_q <= status_d;
      end
   end

endmodule
